// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, forwarding selects,
// writeback-source encodings and default datapath widths.
package execute_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_e;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the execute stage; all results wrap modulo 2^DATA_W.
module alu
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic [4:0] shamt;
  assign shamt = SrcB[4:0];

  always_comb begin
    // NOTE: default assignment first so no path leaves result unassigned (no latch).
    result = '0;
    case (alu_op_e'(ALUControl))
      ALU_ADD: result = SrcA + SrcB;
      ALU_SUB: result = SrcA - SrcB;
      ALU_AND: result = SrcA & SrcB;
      ALU_OR:  result = SrcA | SrcB;
      ALU_XOR: result = SrcA ^ SrcB;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLL: result = SrcA << shamt;
      ALU_SRL: result = SrcA >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the E/M
// pipeline register with stall/flush/bubble handling.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              JumpE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic [1:0]        ResultSrcE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1E,
  input  logic [DATA_W-1:0] RD2E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] ImmExtE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              ValidE,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              StallM,
  input  logic              FlushM,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ValidM,
  output logic [1:0]        ResultSrcM,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M,
  output logic [REG_AW-1:0] RdM
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_result;
  logic              zero;

  // Forwarding from M uses the registered ALUResultM, never this cycle's ALU output.
  always_comb begin
    src_a = RD1E;
    case (fwd_sel_e'(ForwardAE))
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
  end

  always_comb begin
    write_data = RD2E;
    case (fwd_sel_e'(ForwardBE))
      FWD_WB:  write_data = ResultW;
      FWD_MEM: write_data = ALUResultM;
      default: write_data = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : write_data;

  alu #(.DATA_W(DATA_W)) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (ALUControlE),
    .result     (alu_result),
    .zero       (zero)
  );

  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = ValidE & (JumpE | (BranchE & zero));

  // Flush beats stall; an invalid E-stage instruction becomes a bubble unless stalled.
  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || FlushM) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ValidM     <= 1'b0;
      ResultSrcM <= RESULT_ALU;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
    end else if (!StallM) begin
      if (ValidE) begin
        RegWriteM  <= RegWriteE;
        MemWriteM  <= MemWriteE;
        ValidM     <= 1'b1;
        ResultSrcM <= ResultSrcE;
        ALUResultM <= alu_result;
        WriteDataM <= write_data;
        PCPlus4M   <= PCPlus4E;
        RdM        <= RdE;
      end else begin
        RegWriteM  <= 1'b0;
        MemWriteM  <= 1'b0;
        ValidM     <= 1'b0;
        ResultSrcM <= RESULT_ALU;
        ALUResultM <= '0;
        WriteDataM <= '0;
        PCPlus4M   <= '0;
        RdM        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed corner cases plus random
// traffic compared against a behavioural model of the stage.
module tb_execute_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]    ResultSrcE;
  logic [2:0]    ALUControlE;
  logic [DW-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [AW-1:0] RdE;
  logic          ValidE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [DW-1:0] ResultW;
  logic          StallM, FlushM;
  logic          PCSrcE;
  logic [DW-1:0] PCTargetE;
  logic          RegWriteM, MemWriteM, ValidM;
  logic [1:0]    ResultSrcM;
  logic [DW-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [AW-1:0] RdM;

  typedef struct packed {
    logic          rw;
    logic          mw;
    logic          v;
    logic [1:0]    rs;
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [DW-1:0] pc4;
    logic [AW-1:0] rd;
  } m_t;

  m_t exp_m;
  int n_checks;
  int n_fail;

  execute_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RdE(RdE), .ValidE(ValidE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .StallM(StallM), .FlushM(FlushM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ValidM(ValidM),
    .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    longint sa, sb;
    int unsigned sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 1 : 0;
      3'd6: return DW'((64'(a) * (64'd1 << sh)) % (64'd1 << DW));
      default: return DW'(64'(a) / (64'd1 << sh));
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_fwd(input logic [1:0] sel, input logic [DW-1:0] rf);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return exp_m.alu;
    return rf;
  endfunction

  function automatic logic [DW-1:0] ref_result();
    logic [DW-1:0] b;
    b = ALUSrcE ? ImmExtE : ref_fwd(ForwardBE, RD2E);
    return ref_alu(ALUControlE, ref_fwd(ForwardAE, RD1E), b);
  endfunction

  task automatic check_comb(input string tag);
    logic exp_pcsrc;
    #1;
    exp_pcsrc = ValidE && (JumpE || (BranchE && ref_result() == 0));
    check({tag, "_pcsrc"}, DW'(PCSrcE), DW'(exp_pcsrc));
    check({tag, "_pctarget"}, PCTargetE, PCE + ImmExtE);
  endtask

  task automatic check_m(input string tag);
    check({tag, "_rw"},  DW'(RegWriteM),  DW'(exp_m.rw));
    check({tag, "_mw"},  DW'(MemWriteM),  DW'(exp_m.mw));
    check({tag, "_v"},   DW'(ValidM),     DW'(exp_m.v));
    check({tag, "_rs"},  DW'(ResultSrcM), DW'(exp_m.rs));
    check({tag, "_alu"}, ALUResultM,      exp_m.alu);
    check({tag, "_wd"},  WriteDataM,      exp_m.wd);
    check({tag, "_pc4"}, PCPlus4M,        exp_m.pc4);
    check({tag, "_rd"},  DW'(RdM),        DW'(exp_m.rd));
  endtask

  // Advance one clock: predict the E/M contents, then compare after the edge.
  task automatic step(input string tag);
    m_t nxt;
    if (FlushM || (!StallM && !ValidE)) nxt = '0;
    else if (StallM) nxt = exp_m;
    else nxt = '{rw: RegWriteE, mw: MemWriteE, v: 1'b1, rs: ResultSrcE, alu: ref_result(),
                 wd: ref_fwd(ForwardBE, RD2E), pc4: PCPlus4E, rd: RdE};
    @(posedge clk);
    exp_m = nxt;
    #1;
    check_m(tag);
  endtask

  task automatic set_idle();
    {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE} = '0;
    ResultSrcE = 2'd0; ALUControlE = 3'd0;
    RD1E = '0; RD2E = '0; PCE = '0; ImmExtE = '0; PCPlus4E = '0;
    RdE = '0; ValidE = 1'b0; ForwardAE = 2'd0; ForwardBE = 2'd0;
    ResultW = '0; StallM = 1'b0; FlushM = 1'b0;
  endtask

  task automatic randomize_inputs(input bit allow_ctl);
    RegWriteE   = 1'($urandom);
    MemWriteE   = 1'($urandom);
    JumpE       = ($urandom_range(0, 7) == 0);
    BranchE     = 1'($urandom);
    ALUSrcE     = 1'($urandom);
    ResultSrcE  = 2'($urandom);
    ALUControlE = 3'($urandom);
    RD1E        = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom;
    RD2E        = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
    PCE         = $urandom;
    ImmExtE     = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom;
    PCPlus4E    = $urandom;
    RdE         = AW'($urandom);
    ValidE      = ($urandom_range(0, 4) != 0);
    ForwardAE   = 2'($urandom);
    ForwardBE   = 2'($urandom);
    ResultW     = $urandom;
    if (allow_ctl) begin
      StallM = ($urandom_range(0, 5) == 0);
      FlushM = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    m_t snap;
    n_checks = 0;
    n_fail   = 0;
    exp_m    = '0;
    set_idle();
    rst_n = 1'b0;
    #3;
    check_m("reset");
    #9 rst_n = 1'b1;

    // Basic ADD with immediate.
    set_idle();
    RD1E = 32'd5; ImmExtE = 32'd7; ALUSrcE = 1'b1; ALUControlE = 3'b000;
    RdE = 5'd3; RegWriteE = 1'b1; ValidE = 1'b1;
    step("add_imm");
    check("add_imm_alu_const", ALUResultM, 32'd12);
    check("add_imm_rd_const", DW'(RdM), 32'd3);

    // Branch taken via forwarded ALUResultM; then same cycle with ValidE=0.
    set_idle();
    ForwardAE = 2'b10; RD1E = 32'd99; RD2E = 32'd12; ALUControlE = 3'b001;
    BranchE = 1'b1; PCE = 32'h100; ImmExtE = 32'h20; ValidE = 1'b1; RegWriteE = 1'b1;
    check_comb("beq_fwd");
    check("beq_fwd_pcsrc_const", DW'(PCSrcE), 32'd1);
    check("beq_fwd_target_const", PCTargetE, 32'h120);
    ValidE = 1'b0;
    check_comb("beq_invalid");
    check("beq_invalid_pcsrc_const", DW'(PCSrcE), 32'd0);
    step("beq_invalid");

    // Load a nonzero state, then stall three cycles with changing inputs.
    set_idle();
    RD1E = 32'hA5A5_0001; RD2E = 32'h1234; ALUControlE = 3'b011; ValidE = 1'b1;
    RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'b10; RdE = 5'd17;
    PCPlus4E = 32'h444;
    step("pre_stall");
    snap = exp_m;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(1'b0);
      StallM = 1'b1; FlushM = 1'b0;
      step("stall");
    end
    check("stall_frozen_alu", ALUResultM, snap.alu);
    check("stall_frozen_rd", DW'(RdM), DW'(snap.rd));
    randomize_inputs(1'b0);
    ValidE = 1'b1; StallM = 1'b1; FlushM = 1'b1;
    step("stall_flush");

    // ALU boundary cases, observed through PCSrcE and ALUResultM.
    set_idle();
    ValidE = 1'b1; BranchE = 1'b1;
    RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; ALUControlE = 3'b101;
    check_comb("slt_neg");
    step("slt_neg");
    check("slt_neg_const", ALUResultM, 32'd1);
    RD1E = 32'd1; RD2E = 32'd31; ALUControlE = 3'b110;
    step("sll_31");
    check("sll_31_const", ALUResultM, 32'h8000_0000);
    RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; ALUControlE = 3'b000;
    check_comb("add_wrap");
    check("add_wrap_zero_const", DW'(PCSrcE), 32'd1);
    step("add_wrap");
    check("add_wrap_const", ALUResultM, 32'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      randomize_inputs(1'b1);
      check_comb("rand");
      step("rand");
    end

    // Asynchronous reset between edges with nonzero outputs.
    set_idle();
    RD1E = 32'h55; ValidE = 1'b1; RegWriteE = 1'b1; RdE = 5'd9;
    step("pre_rst");
    #2 rst_n = 1'b0;
    exp_m = '0;
    #1;
    check_m("async_rst");
    #1 rst_n = 1'b1;
    RD1E = 32'h66; ImmExtE = 32'h1; ALUSrcE = 1'b1; RdE = 5'd4;
    step("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
